// File: rtl/config_stream_tx_if.sv
// -----------------------------------------------------------------------------
// config_stream_tx_if
// Host-side byte channel into config_stream_tx: one packet is a target ID byte
// followed by payload bytes, with cmd_last marking the final byte.
//   cmd_valid  host -> block  byte valid
//   cmd_ready  block -> host  block accepts the byte this cycle
//   cmd_data   host -> block  packet byte (first = target ID, rest = payload)
//   cmd_last   host -> block  final byte of the packet
// -----------------------------------------------------------------------------
interface config_stream_tx_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_last;

  modport master (output cmd_valid, output cmd_data, output cmd_last, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, input cmd_last, output cmd_ready);
endinterface

// File: rtl/config_stream_tx.sv
// -----------------------------------------------------------------------------
// config_stream_tx
// Buffers one host configuration packet completely, then drops `tracing` and
// replays the payload as a gap-free configId/configData burst (one byte per
// cycle) to the configurable blocks of the trace pipeline. Owns the global
// `tracing` enable and restores it once the burst has finished.
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   cmd           slave side of config_stream_tx_if (valid/ready byte channel)
//   tracing_en    host request for tracing while not configuring
//   err_clear     clears the sticky error flags (a same-cycle set wins)
//   tracing       global tracing enable
//   configId      addressed block ID, IDLE_ID when nothing is addressed
//   configData    configuration byte, 0 whenever configId is IDLE_ID
//   busy          a packet is being loaded, buffered or sent
//   err_overflow  sticky: a packet longer than MAX_PAYLOAD was discarded
//   err_bad_id    sticky: a packet with header IDLE_ID was discarded
//
// All outputs are registered from the *next* state, so each output change is
// visible during the state that causes it.
// -----------------------------------------------------------------------------
module config_stream_tx #(
  parameter int unsigned MAX_PAYLOAD = 64,
  parameter logic [7:0]  IDLE_ID     = 8'hFF
) (
  input  logic               clk,
  input  logic               resetn,
  config_stream_tx_if.slave  cmd,
  input  logic               tracing_en,
  input  logic               err_clear,
  output logic               tracing,
  output logic [7:0]         configId,
  output logic [7:0]         configData,
  output logic               busy,
  output logic               err_overflow,
  output logic               err_bad_id
);

  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    S_HDR,
    S_LOAD,
    S_GUARD,
    S_SEND,
    S_TAIL
  } state_t;

  state_t        state, state_d;
  logic [7:0]    target, target_d;
  logic [CW-1:0] count, count_d;   // payload bytes stored
  logic [CW-1:0] idx, idx_d;       // next buffer index to send
  logic          ovf, ovf_d;       // current packet has overflowed
  logic          cmd_ready_q;
  logic          xfer;
  logic          wr_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          set_ovf, set_bad;
  logic [7:0]    id_d, data_d;
  logic          open_d;           // next state accepts host bytes

  logic [7:0]    mem [MAX_PAYLOAD];

  assign cmd.cmd_ready = cmd_ready_q;
  assign xfer          = cmd.cmd_valid && cmd_ready_q;

  // Next-state and next-output logic.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d  = state;
    target_d = target;
    count_d  = count;
    idx_d    = idx;
    ovf_d    = ovf;
    wr_en    = 1'b0;
    wr_addr  = count[AW-1:0];
    rd_addr  = idx[AW-1:0];
    set_ovf  = 1'b0;
    set_bad  = 1'b0;
    id_d     = IDLE_ID;
    data_d   = 8'h00;

    unique case (state)
      S_HDR: begin
        // A header carrying cmd_last is an empty packet: dropped silently.
        if (xfer && !cmd.cmd_last) begin
          target_d = cmd.cmd_data;
          count_d  = '0;   // every packet restarts at buffer index 0
          ovf_d    = 1'b0;
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        if (xfer) begin
          if (count == MAX_CNT) begin
            ovf_d = 1'b1;  // buffer full: drop the byte, remember it
          end else begin
            wr_en   = 1'b1;
            count_d = count + 1'b1;
          end
          if (cmd.cmd_last) begin
            if (ovf_d || target == IDLE_ID) begin
              set_ovf = ovf_d;
              set_bad = (target == IDLE_ID);
              state_d = S_HDR;
            end else begin
              state_d = S_GUARD;
            end
          end
        end
      end

      S_GUARD: begin
        rd_addr = '0;
        idx_d   = CW'(1);
        state_d = S_SEND;
      end

      S_SEND: begin
        if (idx == count) begin
          state_d = S_TAIL;
        end else begin
          idx_d = idx + 1'b1;
        end
      end

      S_TAIL: state_d = S_HDR;

      default: state_d = S_HDR;
    endcase

    if (state_d == S_SEND) begin
      id_d   = target;
      data_d = mem[rd_addr];
    end
  end

  assign open_d = (state_d == S_HDR) || (state_d == S_LOAD);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_HDR;
      target       <= 8'h00;
      count        <= '0;
      idx          <= '0;
      ovf          <= 1'b0;
      cmd_ready_q  <= 1'b0;
      tracing      <= 1'b0;
      configId     <= IDLE_ID;
      configData   <= 8'h00;
      busy         <= 1'b0;
      err_overflow <= 1'b0;
      err_bad_id   <= 1'b0;
    end else begin
      state        <= state_d;
      target       <= target_d;
      count        <= count_d;
      idx          <= idx_d;
      ovf          <= ovf_d;
      cmd_ready_q  <= open_d;
      tracing      <= open_d ? tracing_en : 1'b0;
      configId     <= id_d;
      configData   <= data_d;
      busy         <= (state_d != S_HDR);
      err_overflow <= set_ovf | (err_overflow & ~err_clear);
      err_bad_id   <= set_bad | (err_bad_id & ~err_clear);
    end
  end

  // NOTE: the payload buffer has no reset; a location is only read after the
  // current packet has written it, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= cmd.cmd_data;
  end

endmodule

// File: tb/tb_config_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_config_stream_tx
// Directed bench for config_stream_tx. Inputs are driven 1 time unit after the
// rising edge and outputs are sampled at the same point; a negedge monitor logs
// accepted host bytes and non-idle output cycles with their cycle numbers.
// -----------------------------------------------------------------------------
module tb_config_stream_tx;

  localparam logic [7:0] IDLE = 8'hFF;

  logic       clk = 1'b0;
  logic       resetn;
  logic       tracing_en;
  logic       err_clear;
  logic       tracing;
  logic [7:0] configId;
  logic [7:0] configData;
  logic       busy;
  logic       err_overflow;
  logic       err_bad_id;

  config_stream_tx_if cmd ();

  config_stream_tx #(.MAX_PAYLOAD(64), .IDLE_ID(8'hFF)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cmd          (cmd),
    .tracing_en   (tracing_en),
    .err_clear    (err_clear),
    .tracing      (tracing),
    .configId     (configId),
    .configData   (configData),
    .busy         (busy),
    .err_overflow (err_overflow),
    .err_bad_id   (err_bad_id)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int sent_cnt = 0;

  typedef struct { int c; logic [7:0] id; logic [7:0] d; } out_ev_t;
  typedef struct { int c; logic [7:0] d; logic last; } acc_ev_t;
  out_ev_t out_log[$];
  acc_ev_t acc_log[$];

  logic [7:0] pl [0:127];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (configId != IDLE) begin
      sent_cnt++;
      out_log.push_back('{cyc, configId, configData});
    end
    if (cmd.cmd_valid && cmd.cmd_ready)
      acc_log.push_back('{cyc, cmd.cmd_data, cmd.cmd_last});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] d, input logic last, input bit gap);
    int w;
    if (gap) begin
      cmd.cmd_valid = 1'b0;
      tick();
    end
    cmd.cmd_valid = 1'b1;
    cmd.cmd_data  = d;
    cmd.cmd_last  = last;
    w = 0;
    while (cmd.cmd_ready !== 1'b1 && w < 300) begin
      tick();
      w++;
    end
    if (w >= 300) check("ready_timeout", 32'd0, 32'd1);
    tick();
  endtask

  // Leaves the bench in cycle t+1 (t = cycle in which the last byte was taken).
  task automatic send_pkt(input logic [7:0] id, input int off, input int n, input bit gap);
    put_byte(id, n == 0, 1'b0);
    for (int i = 0; i < n; i++) put_byte(pl[off+i], i == n - 1, gap);
    cmd.cmd_valid = 1'b0;
    cmd.cmd_last  = 1'b0;
  endtask

  // Called in cycle t+1; walks GUARD, SEND, TAIL and the return to HDR.
  task automatic expect_burst(input string tag, input logic [7:0] id, input int off,
                              input int n, input logic trc_end);
    check({tag, "_guard_trc"}, 32'(tracing), 32'd0);
    check({tag, "_guard_id"}, 32'(configId), 32'(IDLE));
    check({tag, "_guard_rdy"}, 32'(cmd.cmd_ready), 32'd0);
    check({tag, "_guard_busy"}, 32'(busy), 32'd1);
    for (int k = 0; k < n; k++) begin
      tracing_en = k[0];  // must not reach tracing while sending
      tick();
      check({tag, "_send_id"}, 32'(configId), 32'(id));
      check({tag, "_send_data"}, 32'(configData), 32'(pl[off+k]));
      check({tag, "_send_trc"}, 32'(tracing), 32'd0);
    end
    tracing_en = trc_end;
    tick();
    check({tag, "_tail_id"}, 32'(configId), 32'(IDLE));
    check({tag, "_tail_data"}, 32'(configData), 32'd0);
    check({tag, "_tail_trc"}, 32'(tracing), 32'd0);
    check({tag, "_tail_rdy"}, 32'(cmd.cmd_ready), 32'd0);
    tick();
    check({tag, "_hdr_rdy"}, 32'(cmd.cmd_ready), 32'd1);
    check({tag, "_hdr_trc"}, 32'(tracing), 32'(trc_end));
    check({tag, "_hdr_busy"}, 32'(busy), 32'd0);
    check({tag, "_hdr_id"}, 32'(configId), 32'(IDLE));
  endtask

  initial begin
    int sc;
    int t;
    resetn        = 1'b0;
    tracing_en    = 1'b1;
    err_clear     = 1'b0;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_data  = 8'h00;
    cmd.cmd_last  = 1'b0;

    // Reset values, then release with tracing_en high.
    repeat (3) tick();
    check("rst_trc", 32'(tracing), 32'd0);
    check("rst_id", 32'(configId), 32'(IDLE));
    check("rst_data", 32'(configData), 32'd0);
    check("rst_rdy", 32'(cmd.cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_errs", 32'({err_overflow, err_bad_id}), 32'd0);
    resetn = 1'b1;
    check("rel_trc_first", 32'(tracing), 32'd0);
    tick();
    check("rel_trc_second", 32'(tracing), 32'd1);
    check("rel_rdy", 32'(cmd.cmd_ready), 32'd1);
    check("rel_id", 32'(configId), 32'(IDLE));

    // Basic 3-byte packet to ID 3.
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
    send_pkt(8'h03, 0, 3, 1'b0);
    expect_burst("p3", 8'h03, 0, 3, 1'b1);

    // Exactly MAX_PAYLOAD bytes is legal.
    for (int i = 0; i < 65; i++) pl[i] = 8'(i);
    sc = sent_cnt;
    send_pkt(8'h10, 0, 64, 1'b0);
    expect_burst("full", 8'h10, 0, 64, 1'b1);
    check("full_no_ovf", 32'(err_overflow), 32'd0);
    check("full_sent_cnt", 32'(sent_cnt - sc), 32'd64);

    // One byte too many: discarded, overflow flagged, then cleared.
    sc = sent_cnt;
    send_pkt(8'h11, 0, 65, 1'b0);
    check("ovf_flag", 32'(err_overflow), 32'd1);
    check("ovf_busy", 32'(busy), 32'd0);
    check("ovf_rdy", 32'(cmd.cmd_ready), 32'd1);
    repeat (3) tick();
    check("ovf_nothing_sent", 32'(sent_cnt - sc), 32'd0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("ovf_cleared", 32'(err_overflow), 32'd0);

    // Header equal to IDLE_ID: discarded, bad-id flagged.
    pl[0] = 8'hAA; pl[1] = 8'hBB;
    sc = sent_cnt;
    send_pkt(8'hFF, 0, 2, 1'b0);
    check("bad_flag", 32'(err_bad_id), 32'd1);
    check("bad_no_ovf", 32'(err_overflow), 32'd0);
    repeat (3) tick();
    check("bad_nothing_sent", 32'(sent_cnt - sc), 32'd0);
    // Set wins over a simultaneous clear.
    err_clear = 1'b1;
    send_pkt(8'hFF, 0, 2, 1'b0);
    check("bad_set_wins", 32'(err_bad_id), 32'd1);
    tick();
    check("bad_cleared", 32'(err_bad_id), 32'd0);
    err_clear = 1'b0;

    // Header-only packet: silently dropped.
    sc = sent_cnt;
    send_pkt(8'h05, 0, 0, 1'b0);
    check("hdr_only_busy", 32'(busy), 32'd0);
    check("hdr_only_rdy", 32'(cmd.cmd_ready), 32'd1);
    check("hdr_only_errs", 32'({err_overflow, err_bad_id}), 32'd0);
    repeat (3) tick();
    check("hdr_only_busy_later", 32'(busy), 32'd0);
    check("hdr_only_nothing_sent", 32'(sent_cnt - sc), 32'd0);

    // cmd_valid toggling during LOAD: burst still contiguous and ordered.
    pl[0] = 8'hA1; pl[1] = 8'hA2; pl[2] = 8'hA3; pl[3] = 8'hA4; pl[4] = 8'hA5;
    send_pkt(8'h07, 0, 5, 1'b1);
    expect_burst("half", 8'h07, 0, 5, 1'b1);

    // Asynchronous reset in the middle of SEND.
    for (int i = 0; i < 8; i++) pl[i] = 8'(8'h30 + i);
    send_pkt(8'h09, 0, 8, 1'b0);
    repeat (3) tick();
    check("mid_in_send", 32'(configId), 32'h09);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_trc", 32'(tracing), 32'd0);
    check("mid_rst_id", 32'(configId), 32'(IDLE));
    check("mid_rst_data", 32'(configData), 32'd0);
    check("mid_rst_rdy", 32'(cmd.cmd_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    check("mid_rel_rdy", 32'(cmd.cmd_ready), 32'd1);
    pl[0] = 8'h55; pl[1] = 8'h66;
    send_pkt(8'h04, 0, 2, 1'b0);
    expect_burst("after_rst", 8'h04, 0, 2, 1'b1);

    // Two packets queued back-to-back: ID 0 (3 bytes) then ID 1 (2 bytes).
    pl[0] = 8'h10; pl[1] = 8'h11; pl[2] = 8'h12; pl[3] = 8'h20; pl[4] = 8'h21;
    out_log.delete();
    acc_log.delete();
    send_pkt(8'h00, 0, 3, 1'b0);
    send_pkt(8'h01, 3, 2, 1'b0);
    repeat (8) tick();
    check("b2b_acc_count", 32'(acc_log.size()), 32'd7);
    check("b2b_out_count", 32'(out_log.size()), 32'd5);
    if (acc_log.size() == 7 && out_log.size() == 5) begin
      t = acc_log[3].c;  // last byte of the first packet
      check("b2b_first_last", 32'(acc_log[3].last), 32'd1);
      check("b2b_hdr2_cycle", 32'(acc_log[4].c - t), 32'd6);
      check("b2b_hdr2_id", 32'(acc_log[4].d), 32'h01);
      for (int k = 0; k < 3; k++) begin
        check("b2b_p0_cycle", 32'(out_log[k].c - t), 32'(2 + k));
        check("b2b_p0_id", 32'(out_log[k].id), 32'h00);
        check("b2b_p0_data", 32'(out_log[k].d), 32'(pl[k]));
      end
      for (int k = 0; k < 2; k++) begin
        check("b2b_p1_cycle", 32'(out_log[3+k].c - t), 32'(10 + k));
        check("b2b_p1_id", 32'(out_log[3+k].id), 32'h01);
        check("b2b_p1_data", 32'(out_log[3+k].d), 32'(pl[3+k]));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
